mem_arbiter: RTL and testbench

- Shares one single-port backing-memory bus between the instruction-fetch port and the data-access port of the pipelined RV32/RV64 core.
- Sits between the fetch/memory-access stages and the memory, in place of a dual-ported memory controller.
- Data accesses normally win, so the memory stage is not stalled.
- A starvation counter guarantees fetch progress.
- Each requester sees one registered response pulse per request.

---
 rtl/mem_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
// -----------
// Shares one single-port backing-memory bus between the instruction-fetch
// port (imem_*) and the data-access port (mem_*) of the pipelined core.
// Data accesses normally win so the memory stage is not stalled. A starvation
// counter forces a pending fetch through after STARVE_LIMIT consecutive data
// grants. Each requester sees exactly one registered ready pulse per request.
//
// Optional feature (macro MEM_ARB_TIMEOUT_EN): a bus watchdog aborts a bus
// access after TIMEOUT_CYCLES cycles without bus_ack and returns an error
// response. Without the macro, a busy access waits for bus_ack indefinitely.
//
// Ports:
//   clk, resetn              clock, asynchronous active-low reset
//   imem_req/addr            fetch request (held until imem_ready), address
//   imem_ready/err/data      fetch response pulse, error, data
//   mem_read_req/write_req   data load/store request (held until mem_ready)
//   mem_addr/wdata/size/signed  data access fields
//   mem_ready/error/rdata    data response pulse, error, load data
//   bus_req/we/addr/wdata/size/signed  backend request (held until bus_ack)
//   bus_ack/rdata/err        backend completion, read data, error
//
// All outputs are registered.

module mem_arbiter #(
    parameter int XLEN           = 64,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            imem_req,
    input  logic [31:0]     imem_addr,
    output logic            imem_ready,
    output logic            imem_err,
    output logic [XLEN-1:0] imem_data,
    input  logic            mem_read_req,
    input  logic            mem_write_req,
    input  logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_wdata,
    input  logic [2:0]      mem_size,
    input  logic            mem_signed,
    output logic            mem_ready,
    output logic            mem_error,
    output logic [XLEN-1:0] mem_rdata,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    output logic [2:0]      bus_size,
    output logic            bus_signed,
    input  logic            bus_ack,
    input  logic [XLEN-1:0] bus_rdata,
    input  logic            bus_err
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $fatal(1, "mem_arbiter: XLEN must be 32 or 64");
        end
        if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve
            $fatal(1, "mem_arbiter: STARVE_LIMIT must be 1..15");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $fatal(1, "mem_arbiter: TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t     state;
    logic [3:0] starve_cnt;
    logic       data_pending;
    logic       fetch_win;
    logic       timeout;

    assign data_pending = mem_read_req | mem_write_req;
    // A pending fetch loses to data until the starve counter saturates.
    assign fetch_win    = imem_req & (~data_pending | (starve_cnt == STARVE_MAX));

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;

    // Counts busy cycles without an ack; restarts on every new access.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            to_cnt <= '0;
        end else if ((state == BUSY_I || state == BUSY_D) && !bus_ack) begin
            to_cnt <= to_cnt + 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end

    assign timeout = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            starve_cnt <= '0;
            imem_ready <= 1'b0;
            imem_err   <= 1'b0;
            imem_data  <= '0;
            mem_ready  <= 1'b0;
            mem_error  <= 1'b0;
            mem_rdata  <= '0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_size   <= '0;
            bus_signed <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_win) begin
                        state      <= BUSY_I;
                        starve_cnt <= '0;
                        bus_req    <= 1'b1;
                        bus_we     <= 1'b0;
                        bus_addr   <= XLEN'(imem_addr);
                        bus_wdata  <= '0;
                        bus_size   <= 3'b010;
                        bus_signed <= 1'b0;
                    end else if (data_pending) begin
                        // Only reachable with imem_req low or counter below limit.
                        if (imem_req) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end else begin
                            starve_cnt <= '0;
                        end
                        if (mem_read_req && mem_write_req) begin
                            // Illegal combined request: answer with an error, no bus cycle.
                            state     <= RESP;
                            mem_ready <= 1'b1;
                            mem_error <= 1'b1;
                            mem_rdata <= '0;
                        end else begin
                            state      <= BUSY_D;
                            bus_req    <= 1'b1;
                            bus_we     <= mem_write_req;
                            bus_addr   <= mem_addr;
                            bus_wdata  <= mem_wdata;
                            bus_size   <= mem_size;
                            bus_signed <= mem_signed;
                        end
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                BUSY_I: begin
                    if (bus_ack) begin
                        state      <= RESP;
                        bus_req    <= 1'b0;
                        imem_ready <= 1'b1;
                        imem_err   <= bus_err;
                        imem_data  <= bus_rdata;
                    end else if (timeout) begin
                        state      <= RESP;
                        bus_req    <= 1'b0;
                        imem_ready <= 1'b1;
                        imem_err   <= 1'b1;
                        imem_data  <= '0;
                    end
                end
                BUSY_D: begin
                    if (bus_ack) begin
                        state     <= RESP;
                        bus_req   <= 1'b0;
                        mem_ready <= 1'b1;
                        mem_error <= bus_err;
                        // Stores return zero data regardless of what the bus drives.
                        mem_rdata <= bus_we ? '0 : bus_rdata;
                    end else if (timeout) begin
                        state     <= RESP;
                        bus_req   <= 1'b0;
                        mem_ready <= 1'b1;
                        mem_error <= 1'b1;
                        mem_rdata <= '0;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    imem_ready <= 1'b0;
                    imem_err   <= 1'b0;
                    imem_data  <= '0;
                    mem_ready  <= 1'b0;
                    mem_error  <= 1'b0;
                    mem_rdata  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. Expected responses are pushed to a
// scoreboard queue when a request is driven; a monitor pops and compares on
// every ready pulse. Inputs change and outputs are sampled on the falling edge.

module tb_mem_arbiter;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            imem_req = 1'b0;
    logic [31:0]     imem_addr = '0;
    logic            imem_ready;
    logic            imem_err;
    logic [XLEN-1:0] imem_data;
    logic            mem_read_req = 1'b0;
    logic            mem_write_req = 1'b0;
    logic [XLEN-1:0] mem_addr = '0;
    logic [XLEN-1:0] mem_wdata = '0;
    logic [2:0]      mem_size = '0;
    logic            mem_signed = 1'b0;
    logic            mem_ready;
    logic            mem_error;
    logic [XLEN-1:0] mem_rdata;
    logic            bus_req;
    logic            bus_we;
    logic [XLEN-1:0] bus_addr;
    logic [XLEN-1:0] bus_wdata;
    logic [2:0]      bus_size;
    logic            bus_signed;
    logic            bus_ack = 1'b0;
    logic [XLEN-1:0] bus_rdata = '0;
    logic            bus_err = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .XLEN(XLEN),
        .STARVE_LIMIT(4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .resetn(resetn),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_err(imem_err), .imem_data(imem_data),
        .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
        .mem_signed(mem_signed),
        .mem_ready(mem_ready), .mem_error(mem_error), .mem_rdata(mem_rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_size(bus_size), .bus_signed(bus_signed),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    typedef struct {
        logic        fetch;
        logic        err;
        logic [63:0] data;
    } resp_t;

    resp_t sb[$];
    resp_t mon_e;
    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic fetch, input logic err, input logic [63:0] data);
        resp_t e;
        e.fetch = fetch;
        e.err   = err;
        e.data  = data;
        sb.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Advance until bus_req is seen high, bounded.
    task automatic wait_bus(input string tag);
        int n = 0;
        step();
        while (!bus_req && n < 20) begin
            step();
            n++;
        end
        chk(tag, {63'b0, bus_req}, 64'd1);
    endtask

    // Hold off k cycles, then pulse bus_ack; returns at the response edge.
    task automatic do_ack(input int k, input logic [63:0] d, input logic e);
        for (int i = 0; i < k; i++) begin
            chk("bus_req_hold", {63'b0, bus_req}, 64'd1);
            step();
        end
        bus_ack   = 1'b1;
        bus_rdata = d;
        bus_err   = e;
        step();
        bus_ack   = 1'b0;
        bus_rdata = '0;
        bus_err   = 1'b0;
    endtask

    // Response monitor: every ready pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (resetn && (imem_ready || mem_ready)) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", {62'b0, imem_ready, mem_ready}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("resp_imem_ready", {63'b0, imem_ready}, {63'b0, mon_e.fetch});
                chk("resp_mem_ready", {63'b0, mem_ready}, {63'b0, ~mon_e.fetch});
                if (mon_e.fetch) begin
                    chk("resp_imem_err", {63'b0, imem_err}, {63'b0, mon_e.err});
                    chk("resp_imem_data", imem_data, mon_e.data);
                end else begin
                    chk("resp_mem_error", {63'b0, mem_error}, {63'b0, mon_e.err});
                    chk("resp_mem_rdata", mem_rdata, mon_e.data);
                end
                $display("txn %s err=%0b data=%h", mon_e.fetch ? "fetch" : "data ",
                         mon_e.fetch ? imem_err : mem_error,
                         mon_e.fetch ? imem_data : mem_rdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset state ----
        step();
        step();
        chk("rst_bus_req", {63'b0, bus_req}, 64'd0);
        chk("rst_bus_addr", bus_addr, 64'd0);
        chk("rst_ready", {62'b0, imem_ready, mem_ready}, 64'd0);
        chk("rst_bus_we_size", {60'b0, bus_we, bus_size}, 64'd0);
        resetn = 1'b1;
        step();

        // ---- single fetch, ack in the first busy cycle ----
        imem_req  = 1'b1;
        imem_addr = 32'h8000_0004;
        push(1'b1, 1'b0, 64'h0000_0000_0010_0093);
        step();
        chk("fetch_bus_req_lat", {63'b0, bus_req}, 64'd1);
        chk("fetch_bus_addr", bus_addr, 64'h8000_0004);
        chk("fetch_bus_size", {61'b0, bus_size}, 64'd2);
        chk("fetch_bus_we", {63'b0, bus_we}, 64'd0);
        do_ack(0, 64'h0000_0000_0010_0093, 1'b0);
        chk("fetch_ready_lat", {63'b0, imem_ready}, 64'd1);
        chk("fetch_bus_req_drop", {63'b0, bus_req}, 64'd0);
        imem_req = 1'b0;
        step();
        chk("fetch_ready_pulse", {63'b0, imem_ready}, 64'd0);

        // ---- priority: data beats a simultaneous fetch ----
        imem_req     = 1'b1;
        imem_addr    = 32'h8000_2000;
        mem_read_req = 1'b1;
        mem_addr     = 64'h8000_1000;
        mem_size     = 3'b011;
        push(1'b0, 1'b0, 64'h1111_2222_3333_4444);
        push(1'b1, 1'b0, 64'h0000_0000_0000_0013);
        step();
        chk("prio_data_first", bus_addr, 64'h8000_1000);
        chk("prio_data_size", {61'b0, bus_size}, 64'd3);
        do_ack(2, 64'h1111_2222_3333_4444, 1'b0);
        chk("prio_data_ready", {63'b0, mem_ready}, 64'd1);
        mem_read_req = 1'b0;
        wait_bus("prio_fetch_req");
        chk("prio_fetch_next", bus_addr, 64'h8000_2000);
        do_ack(0, 64'h0000_0000_0000_0013, 1'b0);
        imem_req = 1'b0;
        step();

        // ---- starvation: 4 data grants, then the fetch is forced ----
        imem_req     = 1'b1;
        imem_addr    = 32'h8000_3000;
        mem_read_req = 1'b1;
        mem_size     = 3'b011;
        for (int i = 0; i < 4; i++) begin
            mem_addr = 64'h9000_0000 + 64'(i * 8);
            push(1'b0, 1'b0, 64'hA000_0000 + 64'(i));
            wait_bus("starve_data_req");
            chk("starve_data_grant", bus_addr, 64'h9000_0000 + 64'(i * 8));
            do_ack(0, 64'hA000_0000 + 64'(i), 1'b0);
        end
        mem_addr = 64'h9000_0100;
        push(1'b1, 1'b0, 64'h0000_0000_00B0_0001);
        push(1'b0, 1'b0, 64'h0000_0000_00C0_0005);
        wait_bus("starve_fetch_req");
        chk("starve_fetch_wins", bus_addr, 64'h8000_3000);
        do_ack(1, 64'h0000_0000_00B0_0001, 1'b0);
        imem_addr = 32'h8000_3004;
        push(1'b1, 1'b0, 64'h0000_0000_00B0_0002);
        wait_bus("starve_clr_req");
        chk("starve_counter_cleared", bus_addr, 64'h9000_0100);
        do_ack(0, 64'h0000_0000_00C0_0005, 1'b0);
        mem_read_req = 1'b0;
        wait_bus("starve_fetch2_req");
        chk("starve_fetch2", bus_addr, 64'h8000_3004);
        do_ack(0, 64'h0000_0000_00B0_0002, 1'b0);
        imem_req = 1'b0;
        step();

        // ---- signed byte load ----
        mem_read_req = 1'b1;
        mem_addr     = 64'h8000_4008;
        mem_size     = 3'b000;
        mem_signed   = 1'b1;
        push(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FF80);
        wait_bus("load_req");
        chk("load_bus_signed", {63'b0, bus_signed}, 64'd1);
        chk("load_bus_size", {61'b0, bus_size}, 64'd0);
        do_ack(0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
        mem_read_req = 1'b0;
        mem_signed   = 1'b0;
        step();

        // ---- stores: clean store returns 0, erroring store flags error ----
        mem_write_req = 1'b1;
        mem_addr      = 64'h8000_4000;
        mem_wdata     = 64'hDEAD_BEEF;
        mem_size      = 3'b010;
        push(1'b0, 1'b0, 64'd0);
        wait_bus("store_req");
        chk("store_bus_we", {63'b0, bus_we}, 64'd1);
        chk("store_bus_wdata", bus_wdata, 64'hDEAD_BEEF);
        chk("store_bus_addr", bus_addr, 64'h8000_4000);
        do_ack(0, 64'h5555_5555_5555_5555, 1'b0);
        mem_write_req = 1'b0;
        step();
        mem_write_req = 1'b1;
        mem_addr      = 64'h8000_4010;
        push(1'b0, 1'b1, 64'd0);
        wait_bus("store_err_req");
        do_ack(0, 64'h0000_0000_0000_1234, 1'b1);
        chk("store_err_ready", {63'b0, mem_ready}, 64'd1);
        mem_write_req = 1'b0;
        step();

        // ---- illegal read+write: error at N+1, no bus cycle ----
        mem_read_req  = 1'b1;
        mem_write_req = 1'b1;
        push(1'b0, 1'b1, 64'd0);
        step();
        chk("illegal_ready_lat", {63'b0, mem_ready}, 64'd1);
        chk("illegal_no_bus", {63'b0, bus_req}, 64'd0);
        mem_read_req  = 1'b0;
        mem_write_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("illegal_no_bus_after", {63'b0, bus_req}, 64'd0);
        end

        // ---- asynchronous reset mid data access: no response ----
        mem_read_req = 1'b1;
        mem_addr     = 64'h8000_5000;
        wait_bus("rst_mid_req");
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_bus_req", {63'b0, bus_req}, 64'd0);
        chk("async_rst_bus_addr", bus_addr, 64'd0);
        chk("async_rst_ready", {62'b0, imem_ready, mem_ready}, 64'd0);
        step();
        mem_read_req = 1'b0;
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_quiet", {61'b0, bus_req, imem_ready, mem_ready}, 64'd0);
        end

`ifdef MEM_ARB_TIMEOUT_EN
        // ---- watchdog: 8 busy cycles, error pulse, late ack ignored ----
        begin
            int n;
            imem_req  = 1'b1;
            imem_addr = 32'h8000_6000;
            push(1'b1, 1'b1, 64'd0);
            wait_bus("timeout_req");
            n = 0;
            while (bus_req && n < 30) begin
                n++;
                step();
            end
            chk("timeout_busy_cycles", 64'(n), 64'd8);
            chk("timeout_ready", {63'b0, imem_ready}, 64'd1);
            imem_req = 1'b0;
            step();
            bus_ack   = 1'b1;
            bus_rdata = 64'hBAD0_BAD0;
            step();
            bus_ack   = 1'b0;
            bus_rdata = '0;
            chk("late_ack_ignored", {61'b0, bus_req, imem_ready, mem_ready}, 64'd0);
            step();
            chk("late_ack_quiet", {61'b0, bus_req, imem_ready, mem_ready}, 64'd0);
        end
`endif

        step();
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
